// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and flag logic of an async FIFO: binary/Gray write pointer,
// full / almost-full / level estimate against the synced read pointer, sticky overflow.
module wptr_full_ctrl #(
    parameter int ADDRSIZE     = 8,
    parameter int AFULL_MARGIN = 4
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                winc,
    input  logic                wovf_clr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                wen,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] AFULL_TH = (ADDRSIZE+1)'((1 << ADDRSIZE) - AFULL_MARGIN);

    logic [ADDRSIZE:0] wbin_q, wbin_d;
    logic [ADDRSIZE:0] wptr_q, wptr_d;
    logic [ADDRSIZE:0] wlevel_q, wlevel_d;
    logic [ADDRSIZE:0] rbin_s;
    logic              wfull_q, wfull_d;
    logic              wafull_q, wafull_d;
    logic              wovf_q, wovf_d;

    always_comb begin
        wen    = winc & ~wfull_q & ~wrst;
        wbin_d = wbin_q + {{ADDRSIZE{1'b0}}, wen};
        wptr_d = (wbin_d >> 1) ^ wbin_d;

        // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
        rbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++)
            rbin_s[i] = ^(wq2_rptr >> i);

        wlevel_d = wbin_d - rbin_s;
        wfull_d  = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
        wafull_d = (wlevel_d >= AFULL_TH);

        // A blocked write sets overflow even if a clear arrives in the same cycle.
        wovf_d = wovf_q;
        if (winc && wfull_q)
            wovf_d = 1'b1;
        else if (wovf_clr)
            wovf_d = 1'b0;

        if (wrst) begin
            wbin_d   = '0;
            wptr_d   = '0;
            wlevel_d = '0;
            wfull_d  = 1'b0;
            wafull_d = 1'b0;
            wovf_d   = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        wbin_q   <= wbin_d;
        wptr_q   <= wptr_d;
        wlevel_q <= wlevel_d;
        wfull_q  <= wfull_d;
        wafull_q <= wafull_d;
        wovf_q   <= wovf_d;
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Directed + random bench for wptr_full_ctrl (ADDRSIZE=3, AFULL_MARGIN=2) against a
// write/read-count occupancy model.
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       wrst, winc, wovf_clr;
    logic [3:0] wq2_rptr;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       wfull, walmost_full, woverflow;
    logic [3:0] wlevel;

    wptr_full_ctrl #(.ADDRSIZE(3), .AFULL_MARGIN(2)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wovf_clr(wovf_clr), .wq2_rptr(wq2_rptr),
        .wen(wen), .waddr(waddr), .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
        .wlevel(wlevel), .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    // Model: total writes accepted and total reads the write side has seen.
    int   wr, rd;
    int   m_lvl;
    logic m_full, m_afull, m_ovf;
    logic [3:0] prev_wptr;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic i_w, input logic i_c, input logic i_r);
        logic e_wen;
        winc = i_w; wovf_clr = i_c; wrst = i_r; wq2_rptr = gray(rd[3:0]);
        e_wen = i_w && !m_full && !i_r;
        @(negedge wclk);
        chk("wen", {31'b0, wen}, {31'b0, e_wen});
        prev_wptr = wptr;
        @(posedge wclk);
        if (i_r) begin
            wr = 0; rd = 0; m_lvl = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        end else begin
            if (i_w && m_full) m_ovf = 1'b1;
            else if (i_c)      m_ovf = 1'b0;
            if (e_wen) wr++;
            m_lvl   = (wr - rd) & 15;
            m_full  = (m_lvl == 8);
            m_afull = (m_lvl >= 6);
        end
        #1;
        chk("wptr",   {28'b0, wptr},   {28'b0, gray(wr[3:0])});
        chk("waddr",  {29'b0, waddr},  {29'b0, wr[2:0]});
        chk("wfull",  {31'b0, wfull},  {31'b0, m_full});
        chk("wafull", {31'b0, walmost_full}, {31'b0, m_afull});
        chk("wlevel", {28'b0, wlevel}, m_lvl);
        chk("wovf",   {31'b0, woverflow}, {31'b0, m_ovf});
    endtask

    initial begin
        wr = 0; rd = 0; m_lvl = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; wq2_rptr = '0;
        @(posedge wclk); #1;

        // 1: reset, then fill 8 entries
        cyc(0, 0, 1);
        chk("rst_wptr", {28'b0, wptr}, 0);
        chk("rst_wlevel", {28'b0, wlevel}, 0);
        for (int i = 0; i < 8; i++) cyc(1, 0, 0);
        chk("t1_wfull", {31'b0, wfull}, 1);
        chk("t1_wptr", {28'b0, wptr}, 32'hC);
        chk("t1_waddr", {29'b0, waddr}, 0);
        chk("t1_wlevel", {28'b0, wlevel}, 8);

        // 2: write while full -> dropped, sticky overflow, set beats clear
        cyc(1, 0, 0);
        chk("t2_wptr", {28'b0, wptr}, 32'hC);
        chk("t2_ovf", {31'b0, woverflow}, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        chk("t2_ovf_hold", {31'b0, woverflow}, 1);
        cyc(1, 1, 0);
        chk("t2_set_wins", {31'b0, woverflow}, 1);
        cyc(0, 1, 0);
        chk("t2_ovf_clr", {31'b0, woverflow}, 0);

        // 3: almost-full threshold at level 6
        cyc(0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0);
        chk("t3_afull5", {31'b0, walmost_full}, 0);
        chk("t3_lvl5", {28'b0, wlevel}, 5);
        cyc(1, 0, 0);
        chk("t3_afull6", {31'b0, walmost_full}, 1);
        chk("t3_full6", {31'b0, wfull}, 0);

        // 4: full, one read seen -> not full, level 7; one more write -> full
        cyc(1, 0, 0);
        cyc(1, 0, 0);
        chk("t4_full", {31'b0, wfull}, 1);
        rd = 1;
        cyc(0, 0, 0);
        chk("t4_notfull", {31'b0, wfull}, 0);
        chk("t4_lvl7", {28'b0, wlevel}, 7);
        chk("t4_afull", {31'b0, walmost_full}, 1);
        cyc(1, 0, 0);
        chk("t4_refull", {31'b0, wfull}, 1);

        // 5: 20 writes with reader trailing by two; Gray single-bit steps and wrap
        cyc(0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            rd = (wr >= 2) ? wr - 2 : 0;
            cyc(1, 0, 0);
            chk("t5_gray1bit", $countones(prev_wptr ^ wptr), 1);
            if (wr == 16) begin
                chk("t5_wrap_from", {28'b0, prev_wptr}, 32'h8);
                chk("t5_wrap_to", {28'b0, wptr}, 0);
            end
        end

        // 6: reset mid-stream with a write request
        rd = wr - 1;
        cyc(1, 0, 1);
        chk("t6_wptr", {28'b0, wptr}, 0);
        chk("t6_wfull", {31'b0, wfull}, 0);
        chk("t6_wlevel", {28'b0, wlevel}, 0);
        chk("t6_wovf", {31'b0, woverflow}, 0);

        // random traffic with a lagging, monotonic reader
        for (int i = 0; i < 400; i++) begin
            logic w, c, r;
            if (rd < wr && $urandom_range(0, 2) == 0) rd++;
            w = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 63) == 0);
            cyc(w, c, r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
